// File: rtl/jts16_fd1089_loader_if.sv
// Download-side and decryptor-side bus of the FD1089 key/LUT loader.
// The master is the download controller plus decryptor; the slave is the loader.
interface jts16_fd1089_loader_if #(
    parameter int unsigned KEY_AW = 13
);
    logic              dwn_start;
    logic              dwn_we;
    logic [7:0]        dwn_data;
    logic [KEY_AW-1:0] key_addr;
    logic [7:0]        key_data;
    logic [12:0]       prog_addr;
    logic [7:0]        prog_data;
    logic              fd1089_we;
    logic              dec_en;
    logic              dec_type;
    logic              done;
    logic              err;
    logic [15:0]       checksum;

    modport master (
        output dwn_start, dwn_we, dwn_data, key_addr,
        input  key_data, prog_addr, prog_data, fd1089_we, dec_en, dec_type, done, err,
               checksum
    );

    modport slave (
        input  dwn_start, dwn_we, dwn_data, key_addr,
        output key_data, prog_addr, prog_data, fd1089_we, dec_en, dec_type, done, err,
               checksum
    );
endinterface

// File: rtl/jts16_fd1089_loader.sv
// FD1089 loader: stores key bytes in RAM, forwards LUT bytes as PROM writes,
// latches the config byte and tracks stream errors and a running checksum.
module jts16_fd1089_loader #(
    parameter int unsigned KEY_AW = 13,
    parameter int unsigned LUT_AW = 8
) (
    input  logic                      rst,
    input  logic                      clk,
    jts16_fd1089_loader_if.slave      bus
);
    localparam int unsigned KeyLen = 2 ** KEY_AW;
    localparam int unsigned ProgAw = 13;

    typedef enum logic [2:0] {StIdle, StKey, StLut, StCfg, StDone} state_t;

    state_t              r_state;
    logic [KEY_AW-1:0]   r_cnt;
    logic [7:0]          r_key_ram [KeyLen];
    logic [7:0]          r_key_data;
    logic [ProgAw-1:0]   r_prog_addr;
    logic [7:0]          r_prog_data;
    logic                r_we;
    logic                r_dec_en;
    logic                r_dec_type;
    logic                r_done;
    logic                r_err;
    logic [15:0]         r_checksum;

    logic w_loading;
    logic w_accept;
    logic w_key_last;
    logic w_lut_last;

    always_comb begin
        w_loading  = (r_state == StKey) || (r_state == StLut) || (r_state == StCfg);
        // A byte arriving together with dwn_start is dropped.
        w_accept   = bus.dwn_we && !bus.dwn_start && w_loading;
        w_key_last = &r_cnt;
        w_lut_last = &r_cnt[LUT_AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_we        <= 1'b0;
            r_dec_en    <= 1'b0;
            r_dec_type  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_we <= 1'b0;
            if (bus.dwn_start) begin
                r_state    <= StKey;
                r_cnt      <= '0;
                r_checksum <= '0;
                r_dec_en   <= 1'b0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_checksum <= r_checksum + 16'(bus.dwn_data);
                end
                unique case (r_state)
                    StKey: begin
                        if (bus.dwn_we) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (w_key_last) begin
                                r_state <= StLut;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    StLut: begin
                        if (bus.dwn_we) begin
                            r_we        <= 1'b1;
                            r_prog_addr <= ProgAw'(r_cnt[LUT_AW-1:0]);
                            r_prog_data <= bus.dwn_data;
                            r_cnt       <= r_cnt + 1'b1;
                            if (w_lut_last) begin
                                r_state <= StCfg;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    StCfg: begin
                        if (bus.dwn_we) begin
                            r_dec_en   <= bus.dwn_data[7];
                            r_dec_type <= bus.dwn_data[0];
                            r_done     <= 1'b1;
                            r_state    <= StDone;
                        end
                    end
                    StDone: begin
                        if (bus.dwn_we) begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && (r_state == StKey)) begin
            r_key_ram[r_cnt] <= bus.dwn_data;
        end
    end

    // The decryptor bypasses while a load is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_data <= '0;
        end else if (w_loading) begin
            r_key_data <= '0;
        end else begin
            r_key_data <= r_key_ram[bus.key_addr];
        end
    end

    assign bus.key_data  = r_key_data;
    assign bus.prog_addr = r_prog_addr;
    assign bus.prog_data = r_prog_data;
    assign bus.fd1089_we = r_we;
    assign bus.dec_en    = r_dec_en;
    assign bus.dec_type  = r_dec_type;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.checksum  = r_checksum;
endmodule

// File: tb/tb_jts16_fd1089_loader.sv
// Scoreboard bench for jts16_fd1089_loader: LUT writes and key reads are queued
// by the stimulus and checked by a free-running monitor.
module tb_jts16_fd1089_loader;
    localparam int KeyAw  = 13;
    localparam int LutAw  = 8;
    localparam int KeyLen = 8192;
    localparam int LutLen = 256;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } lut_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jts16_fd1089_loader_if #(.KEY_AW(KeyAw)) bus();

    jts16_fd1089_loader #(.KEY_AW(KeyAw), .LUT_AW(LutAw)) u_dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    lut_t       q_lut[$];
    logic [7:0] q_key[$];
    int         lut_pulses = 0;
    logic       key_rd = 1'b0;
    logic       key_rd_d = 1'b0;
    logic [15:0] model_sum;
    logic [15:0] sum_first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            key_rd_d = key_rd;
        end
    end

    // Monitor: pops expected values whenever the DUT presents a LUT write or key read result.
    initial begin
        lut_t       e;
        logic [7:0] k;
        forever begin
            @(negedge clk);
            if (bus.fd1089_we === 1'b1) begin
                lut_pulses++;
                if (q_lut.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL lut_extra_we: prog_addr=0x%0h prog_data=0x%0h, expected no write",
                             bus.prog_addr, bus.prog_data);
                end else begin
                    e = q_lut.pop_front();
                    chk("prog_addr", 32'(bus.prog_addr), 32'(e.addr));
                    chk("prog_data", 32'(bus.prog_data), 32'(e.data));
                end
            end
            if (key_rd_d) begin
                if (q_key.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL key_extra_read: key_data=0x%0h, expected no read", bus.key_data);
                end else begin
                    k = q_key.pop_front();
                    chk("key_data", 32'(bus.key_data), 32'(k));
                end
            end
        end
    end

    task automatic cyc(input logic st, input logic we, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.dwn_start = st;
        bus.dwn_we    = we;
        bus.dwn_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic gap(input int max_gap);
        if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_key_data", 32'(bus.key_data), 0);
        chk("rst_prog_addr", 32'(bus.prog_addr), 0);
        chk("rst_prog_data", 32'(bus.prog_data), 0);
        chk("rst_fd1089_we", 32'(bus.fd1089_we), 0);
        chk("rst_dec_en", 32'(bus.dec_en), 0);
        chk("rst_dec_type", 32'(bus.dec_type), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_checksum", 32'(bus.checksum), 0);
    endtask

    // Full load; abort_at >= 0 stops after that many key bytes.
    task automatic load(input logic [7:0] cfg, input int max_gap, input int abort_at,
                        input logic start_we);
        lut_t       e;
        logic [7:0] b;
        model_sum  = '0;
        lut_pulses = 0;
        cyc(1'b1, start_we, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("start_checksum", 32'(bus.checksum), 0);
        chk("start_done", 32'(bus.done), 0);
        chk("start_err", 32'(bus.err), 0);
        chk("start_dec_en", 32'(bus.dec_en), 0);
        for (int i = 0; i < KeyLen; i++) begin
            if (i == abort_at) return;
            gap(max_gap);
            b = i[7:0] ^ 8'h5A;
            cyc(1'b0, 1'b1, b);
            model_sum = model_sum + 16'(b);
            if (i == 100) begin
                @(negedge clk);
                chk("key_data_bypass", 32'(bus.key_data), 0);
                chk("key_dec_en", 32'(bus.dec_en), 0);
            end
        end
        for (int i = 0; i < LutLen; i++) begin
            gap(max_gap);
            b      = ~i[7:0];
            e.addr = 13'(i);
            e.data = b;
            q_lut.push_back(e);
            cyc(1'b0, 1'b1, b);
            model_sum = model_sum + 16'(b);
        end
        gap(max_gap);
        cyc(1'b0, 1'b1, cfg);
        model_sum = model_sum + 16'(cfg);
        idle(3);
    endtask

    task automatic check_done(input logic [7:0] cfg);
        @(negedge clk);
        chk("done", 32'(bus.done), 1);
        chk("err", 32'(bus.err), 0);
        chk("dec_en", 32'(bus.dec_en), 32'(cfg[7]));
        chk("dec_type", 32'(bus.dec_type), 32'(cfg[0]));
        chk("checksum", 32'(bus.checksum), 32'(model_sum));
        chk("lut_pulses", 32'(lut_pulses), LutLen);
        chk("lut_queue_empty", 32'(q_lut.size()), 0);
    endtask

    task automatic sweep(input int n);
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            a = 13'(i);
            @(posedge clk);
            #1;
            bus.key_addr = a;
            key_rd       = 1'b1;
            q_key.push_back(a[7:0] ^ 8'h5A);
        end
        @(posedge clk);
        #1;
        key_rd       = 1'b0;
        bus.key_addr = 13'd3;
        idle(2);
        @(negedge clk);
        chk("key_queue_empty", 32'(q_key.size()), 0);
    endtask

    initial begin
        bus.dwn_start = 1'b0;
        bus.dwn_we    = 1'b0;
        bus.dwn_data  = 8'h00;
        bus.key_addr  = 13'd3;
        repeat (3) @(posedge clk);
        check_reset();
        #1;
        rst = 1'b0;
        idle(2);

        // Gapless load, then a full key readback.
        load(8'h81, 0, -1, 1'b0);
        check_done(8'h81);
        chk("checksum_const", 32'(bus.checksum), 32'h7001);
        sum_first = model_sum;
        sweep(KeyLen);

        // Back-to-back reload with random gaps must give the same result.
        load(8'h81, 5, -1, 1'b0);
        check_done(8'h81);
        chk("checksum_gapped", 32'(bus.checksum), 32'(sum_first));

        // Config 0x00, then an extra byte in DONE.
        load(8'h00, 0, -1, 1'b0);
        check_done(8'h00);
        cyc(1'b0, 1'b1, 8'h33);
        idle(3);
        @(negedge clk);
        chk("extra_err", 32'(bus.err), 1);
        chk("extra_checksum", 32'(bus.checksum), 32'(model_sum));
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("restart_err", 32'(bus.err), 0);
        chk("restart_done", 32'(bus.done), 0);

        // Reset in the middle of the key stream.
        load(8'h81, 0, 4000, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.dwn_we = 1'b0;
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 8'h77);
        idle(3);
        @(negedge clk);
        chk("idle_err", 32'(bus.err), 0);
        chk("idle_checksum", 32'(bus.checksum), 0);
        chk("idle_done", 32'(bus.done), 0);

        // Start with a simultaneous 0xFF byte: it must be dropped.
        load(8'h81, 0, -1, 1'b1);
        check_done(8'h81);
        chk("drop_checksum", 32'(bus.checksum), 32'h7001);
        sweep(16);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/jts16_fd1089_loader.md
Name: jts16_fd1089_loader

Overview:
- Write side of the FD1089 decryptor's key/LUT interface.
- Consumes the FD1089 section of the download stream: 8192 key bytes, then 256 LUT bytes, then 1 configuration byte.
- Stores key bytes in internal RAM and serves them on the decryptor's key read port. Forwards LUT bytes as registered PROM writes.
- Latches decoder enable and variant from the config byte. Reports completion, stream errors and a running checksum to the download controller.

Parameters:
KEY_AW, 13, key RAM address width (key length = 2**KEY_AW bytes)
LUT_AW, 8, LUT PROM address width (LUT length = 2**LUT_AW bytes)

Ports:
rst        input   1        asynchronous reset, active-high
clk        input   1        system clock
dwn_start  input   1        one-cycle pulse: begin a new FD1089 load
dwn_we     input   1        dwn_data valid this cycle
dwn_data   input   8        download byte
key_addr   input   KEY_AW   key read address from the decryptor
key_data   output  8        key byte, registered, 1-cycle latency
prog_addr  output  13       LUT write address (upper bits always 0)
prog_data  output  8        LUT write data
fd1089_we  output  1        LUT write strobe
dec_en     output  1        decryption enable
dec_type   output  1        0 = FD1089A, 1 = FD1089B
done       output  1        load complete
err        output  1        sticky stream error
checksum   output  16       wrap-around sum of accepted bytes

Behaviour:
- Reset values: key_data=0, prog_addr=0, prog_data=0, fd1089_we=0, dec_en=0, dec_type=0, done=0, err=0, checksum=0, state=IDLE, byte counter=0. Key RAM contents are undefined after reset.
- States: IDLE, KEY, LUT, CFG, DONE. The byte counter is KEY_AW bits wide.
- A byte is accepted when dwn_we=1 in KEY, LUT or CFG.
- dwn_start in any state:
  - next state KEY; counter=0; checksum=0.
  - dec_en=0, done=0, err=0.
  - If dwn_we is also high that cycle, the byte is dropped and not counted.
- KEY:
  - Accepted byte is written to key RAM[counter]; counter increments.
  - On accepting byte 2**KEY_AW-1: go to LUT, counter=0.
- LUT:
  - Accepted byte produces fd1089_we=1 on the next cycle, with prog_addr=counter[LUT_AW-1:0] and prog_data=byte.
  - fd1089_we is low on every cycle without an accepted LUT byte.
  - After accepting byte 2**LUT_AW-1: go to CFG.
- CFG:
  - Accepted byte is the config byte.
  - Next cycle: dec_en=byte[7], dec_type=byte[0], done=1, state=DONE.
  - Bits 6:1 are ignored.
- DONE:
  - Any dwn_we without dwn_start sets err=1; the byte is not accepted.
  - err stays set until the next dwn_start or rst.
- IDLE: dwn_we is ignored with no error.
- Checksum: 16-bit sum of every accepted byte (key, LUT, config), wrapping modulo 2**16. It updates one cycle after acceptance.
- Key read port:
  - key_data <= RAM[key_addr] each cycle.
  - In states KEY, LUT and CFG, key_data is forced to 0, so the decryptor bypasses. dec_en is also 0 in these states.
- Gaps: dwn_we may be low for any number of cycles. State and counter hold. No timeout.
- Reset mid-load: everything returns to reset values; the partial load is abandoned.
- Back-to-back loads: dwn_start in DONE reloads fully. dec_en drops the cycle after dwn_start and stays low until the new CFG byte is taken.

Test Plan:
- Reset, then dwn_start; stream 8192 key bytes (value = addr[7:0]^8'h5A), 256 LUT bytes (value = ~addr), config 8'h81 -> exactly 256 fd1089_we pulses with prog_addr 0..255 and prog_data=~addr; done=1, dec_en=1, dec_type=1, err=0; checksum equals the 16-bit model sum.
- After the first load, sweep key_addr 0..8191 -> key_data = addr[7:0]^8'h5A, one cycle after each address.
- During the KEY state, drive key_addr=3 -> key_data=0. Insert random dwn_we gaps of 0-5 cycles -> same final LUT writes and checksum as the gapless run.
- Config 8'h00 -> dec_en=0, dec_type=0, done=1. One extra dwn_we byte -> err=1, checksum unchanged. Next dwn_start -> err=0, done=0.
- Assert rst at key byte 4000 -> all outputs return to 0, state IDLE. A new full load completes correctly.
- dwn_start and dwn_we in the same cycle with data 8'hFF -> byte dropped; counter and checksum remain 0.
